// File: rtl/adder_share_ctrl.sv
// Round-robin arbiter and chunk sequencer sharing one IWL-bit adder slice
// between two requesters; returns a (W+1)-bit sum tagged with the requester ID.
module adder_share_ctrl #(
    parameter  int IWL    = 4,
    parameter  int NCHUNK = 4,
    localparam int W      = IWL * NCHUNK
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W:0]   res_sum,
    output logic         res_id
);

    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_rr_ptr;
    logic [CW-1:0]   r_chunk;
    logic            r_carry;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W:0]      r_sum;
    logic            r_id;

    logic            w_grant_valid;
    logic            w_grant_id;
    logic            w_transfer;
    logic            w_last_chunk;
    logic [IWL:0]    w_slice;

    // rr_ptr only breaks ties; a lone valid is always granted
    assign w_grant_valid = req0_valid | req1_valid;
    assign w_grant_id    = (req0_valid & req1_valid) ? r_rr_ptr : req1_valid;
    assign w_transfer    = (r_state == IDLE) & w_grant_valid;
    assign w_last_chunk  = (r_chunk == LAST_CHUNK);

    assign w_slice = {1'b0, r_a[int'(r_chunk) * IWL +: IWL]}
                   + {1'b0, r_b[int'(r_chunk) * IWL +: IWL]}
                   + {{IWL{1'b0}}, r_carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_next_state = ADD;
            ADD:     if (w_last_chunk)  w_next_state = DONE;
            DONE:    if (res_ready)     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Readys are gated by rst_n so nothing is offered while reset is held
    always_comb begin
        req0_ready = rst_n & w_transfer & ~w_grant_id;
        req1_ready = rst_n & w_transfer &  w_grant_id;
        res_valid  = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
            r_chunk  <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_id     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_transfer) begin
                        r_a      <= w_grant_id ? req1_a : req0_a;
                        r_b      <= w_grant_id ? req1_b : req0_b;
                        r_id     <= w_grant_id;
                        r_rr_ptr <= ~w_grant_id;
                        r_carry  <= 1'b0;
                        r_chunk  <= '0;
                    end
                end
                ADD: begin
                    r_sum[int'(r_chunk) * IWL +: IWL] <= w_slice[IWL-1:0];
                    r_carry <= w_slice[IWL];
                    r_chunk <= r_chunk + 1'b1;
                    if (w_last_chunk) begin
                        r_sum[W] <= w_slice[IWL];
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_sum = r_sum;
    assign res_id  = r_id;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl: directed scenarios plus random
// traffic, compared each cycle against a transaction-level reference model.
module tb_adder_share_ctrl;

    localparam int IWL    = 4;
    localparam int NCHUNK = 4;
    localparam int W      = IWL * NCHUNK;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         res_valid, res_ready;
    logic [W:0]   res_sum;
    logic         res_id;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a request occupies the unit from acceptance until its
    // result is taken; the result appears NCHUNK edges after acceptance.
    logic         mPtr;
    bit           mPending;
    int           mBusy;
    logic [W:0]   mSum;
    logic         mId;
    bit           lastGv;
    logic         lastG;

    adder_share_ctrl #(.IWL(IWL), .NCHUNK(NCHUNK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_id     (res_id)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W:0] observed,
                               input logic [W:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's inputs at the falling edge, checks outputs, advances the model
    task automatic applyStimulus(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                                 input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                                 input logic rr);
        bit   idle;
        bit   gv;
        logic g;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        res_ready  = rr;
        #1;
        idle = !mPending;
        gv   = idle && (v0 || v1);
        g    = (v0 && v1) ? mPtr : v1;
        checkOutput("req0_ready", {{W{1'b0}}, req0_ready}, {{W{1'b0}}, (gv && g == 1'b0)});
        checkOutput("req1_ready", {{W{1'b0}}, req1_ready}, {{W{1'b0}}, (gv && g == 1'b1)});
        checkOutput("res_valid", {{W{1'b0}}, res_valid}, {{W{1'b0}}, (mPending && mBusy == 0)});
        if (mPending && mBusy == 0) begin
            checkOutput("res_sum", res_sum, mSum);
            checkOutput("res_id", {{W{1'b0}}, res_id}, {{W{1'b0}}, mId});
        end else if (!mPending) begin
            checkOutput("res_sum_hold", res_sum, mSum);
        end
        if (gv) begin
            mPending = 1'b1;
            mBusy    = NCHUNK;
            mSum     = g ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
            mId      = g;
            mPtr     = !g;
        end else if (mPending && mBusy > 0) begin
            mBusy--;
        end else if (mPending && rr) begin
            mPending = 1'b0;
        end
        lastGv = gv;
        lastG  = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset with both requesters valid; everything must read as reset
    task automatic doReset();
        rst_n      = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 16'h1111; req0_b = 16'h2222; req1_a = 16'h3333; req1_b = 16'h4444;
        res_ready  = 1'b1;
        #1;
        checkOutput("rst_req0_ready", {{W{1'b0}}, req0_ready}, '0);
        checkOutput("rst_req1_ready", {{W{1'b0}}, req1_ready}, '0);
        checkOutput("rst_res_valid", {{W{1'b0}}, res_valid}, '0);
        checkOutput("rst_res_sum", res_sum, '0);
        checkOutput("rst_res_id", {{W{1'b0}}, res_id}, '0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        mPtr     = 1'b0;
        mPending = 1'b0;
        mBusy    = 0;
        mSum     = '0;
        mId      = 1'b0;
        lastGv   = 1'b0;
        lastG    = 1'b0;
    endtask

    initial begin
        logic         rv0, rv1;
        logic [W-1:0] ra0, rb0, ra1, rb1;

        doReset();

        // Single add without carry, then carry ripples through every chunk
        applyStimulus(1, 16'h1234, 16'h4321, 0, 16'h0, 16'h0, 1);
        repeat (6) applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        applyStimulus(0, 16'h0, 16'h0, 1, 16'hFFFF, 16'h0001, 1);
        repeat (6) applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        applyStimulus(0, 16'h0, 16'h0, 1, 16'hFFFF, 16'hFFFF, 1);
        repeat (6) applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);

        // Contention right after reset: grants must alternate starting with 0
        doReset();
        repeat (26) applyStimulus(1, 16'h0001, 16'h0001, 1, 16'h0010, 16'h0010, 1);

        // Back-pressure with a competing requester waiting
        repeat (6) applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        applyStimulus(1, 16'hBEEF, 16'h1234, 0, 16'h0, 16'h0, 0);
        repeat (14) applyStimulus(0, 16'h0, 16'h0, 1, 16'h7777, 16'h8888, 0);
        applyStimulus(0, 16'h0, 16'h0, 1, 16'h7777, 16'h8888, 1);
        applyStimulus(0, 16'h0, 16'h0, 1, 16'h7777, 16'h8888, 1);
        repeat (6) applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);

        // Reset after chunk 1, then a fresh request shows no residue
        applyStimulus(1, 16'hAAAA, 16'h5555, 0, 16'h0, 16'h0, 1);
        repeat (2) applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        doReset();
        applyStimulus(1, 16'h0F0F, 16'h00F1, 0, 16'h0, 16'h0, 1);
        repeat (6) applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);

        // Idle hold, then contention reveals the preserved rr_ptr
        applyStimulus(0, 16'h0, 16'h0, 1, 16'h0100, 16'h0200, 1);
        repeat (6) applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        repeat (20) applyStimulus(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        repeat (8) applyStimulus(1, 16'h0003, 16'h0004, 1, 16'h0030, 16'h0040, 1);

        // Random traffic; waiting requesters hold valid and operands stable
        rv0 = 1'b0; rv1 = 1'b0;
        ra0 = '0; rb0 = '0; ra1 = '0; rb1 = '0;
        for (int i = 0; i < 500; i++) begin
            if (!rv0 || (lastGv && lastG == 1'b0)) begin
                rv0 = 1'($urandom_range(0, 1));
                ra0 = W'($urandom);
                rb0 = W'($urandom);
            end
            if (!rv1 || (lastGv && lastG == 1'b1)) begin
                rv1 = 1'($urandom_range(0, 1));
                ra1 = W'($urandom);
                rb1 = W'($urandom);
            end
            applyStimulus(rv0, ra0, rb0, rv1, ra1, rb1, 1'($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
